// File: rtl/mem_responder.sv
// Block-memory responder: accepts one read or write request at a time and
// answers after a fixed LATENCY with a single-cycle mem_ready pulse.
module mem_responder #(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned DEPTH_BITS = 8
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready
);

   localparam int unsigned Blocks  = 2 ** DEPTH_BITS;
   localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StResp = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  op_wr_q;
   logic [DEPTH_BITS-1:0] idx_q;
   logic [127:0]          wdata_q;
   logic                  ready_q, ready_d;
   logic [127:0]          rdata_q, rdata_d;
   logic [127:0]          mem_q [Blocks];

   logic                  accept;
   logic                  commit;
   logic [DEPTH_BITS-1:0] rd_idx;
   logic                  rd_op;

   // Upper address bits alias away; fold them so they are not flagged as dangling.
   logic                  addr_unused;
   assign addr_unused = ^mem_addr;

   // Exactly one request bit in IDLE starts a transaction; both or neither is ignored.
   assign accept = (state_q == StIdle) && (mem_read ^ mem_write);
   // Write data lands on the edge that ends RESP.
   assign commit = (state_q == StResp) && op_wr_q;

   // State register, countdown and latched request fields.
   always_ff @(posedge clk or negedge proc_reset) begin
      if (!proc_reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            op_wr_q <= mem_write;
            idx_q   <= mem_addr[DEPTH_BITS-1:0];
            wdata_q <= mem_wdata;
         end
      end
   end

   // Next-state and countdown logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d   = LoadCnt;
               state_d = (LATENCY == 1) ? StResp : StBusy;
            end
         end
         StBusy: begin
            cnt_d = cnt_q - 4'd1;
            // Leave when the decrement reaches zero; <= guards a corrupt zero count.
            if (cnt_q <= 4'd1) begin
               cnt_d   = '0;
               state_d = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered outputs: ready mirrors entry into RESP, rdata loads on entry for reads.
   always_comb begin
      // With LATENCY=1 the request goes straight from IDLE to RESP, so use live inputs.
      rd_idx  = (state_q == StIdle) ? mem_addr[DEPTH_BITS-1:0] : idx_q;
      rd_op   = (state_q == StIdle) ? mem_read : !op_wr_q;
      ready_d = (state_d == StResp);
      rdata_d = rdata_q;
      if ((state_d == StResp) && (state_q != StResp) && rd_op) begin
         rdata_d = mem_q[rd_idx];
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge proc_reset) begin
      if (!proc_reset) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage: one register per block, all cleared by reset.
   for (genvar g = 0; g < Blocks; g++) begin : g_block
      always_ff @(posedge clk or negedge proc_reset) begin
         if (!proc_reset) begin
            mem_q[g] <= '0;
         end else if (commit && (idx_q == DEPTH_BITS'(g))) begin
            mem_q[g] <= wdata_q;
         end
      end
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default LATENCY plus a LATENCY=1 copy).
module tb_mem_responder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         read0 = 1'b0, write0 = 1'b0;
   logic [27:0]  addr0 = '0;
   logic [127:0] wdata0 = '0;
   logic [127:0] rdata0;
   logic         ready0;
   logic         read1 = 1'b0, write1 = 1'b0;
   logic [27:0]  addr1 = '0;
   logic [127:0] wdata1 = '0;
   logic [127:0] rdata1;
   logic         ready1;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] DataA = 128'hDEADBEEF_00000001_00000002_00000003;
   localparam logic [127:0] DataB = 128'hA5;
   localparam logic [127:0] DataX = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] DataY = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
   localparam logic [127:0] DataZ = 128'hCAFE_F00D;
   localparam logic [127:0] DataW = 128'h0123_4567_89AB_CDEF;

   always #5 clk = ~clk;

   mem_responder #(.LATENCY(4), .DEPTH_BITS(8)) dut0 (
      .clk        (clk),
      .proc_reset (rst_n),
      .mem_read   (read0),
      .mem_write  (write0),
      .mem_addr   (addr0),
      .mem_wdata  (wdata0),
      .mem_rdata  (rdata0),
      .mem_ready  (ready0)
   );

   mem_responder #(.LATENCY(1), .DEPTH_BITS(8)) dut1 (
      .clk        (clk),
      .proc_reset (rst_n),
      .mem_read   (read1),
      .mem_write  (write1),
      .mem_addr   (addr1),
      .mem_wdata  (wdata1),
      .mem_rdata  (rdata1),
      .mem_ready  (ready1)
   );

   // Called at a negedge: drives a held request, waits for ready, checks latency and data.
   // Returns at the negedge inside the RESP cycle with the request dropped.
   task automatic run_req(input string name, input bit sel, input bit wr, input logic [27:0] a,
                          input logic [127:0] d, input int exp_lat, input bit chk_rd,
                          input logic [127:0] exp_rd);
      int  n = 0;
      bit  seen = 1'b0;
      logic [127:0] got;
      if (sel) begin
         read1 = !wr; write1 = wr; addr1 = a; wdata1 = d;
      end else begin
         read0 = !wr; write0 = wr; addr0 = a; wdata0 = d;
      end
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if ((sel ? ready1 : ready0) === 1'b1) begin
            seen = 1'b1;
            n    = i;
         end
      end
      checks++;
      if (!seen || n != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, n, seen, exp_lat);
      end
      got = sel ? rdata1 : rdata0;
      if (sel) begin
         read1 = 1'b0; write1 = 1'b0;
      end else begin
         read0 = 1'b0; write0 = 1'b0;
      end
      if (chk_rd) begin
         checks++;
         if (got !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", name, got, exp_rd);
         end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (ready0 !== 1'b0 || rdata0 !== 128'h0 || ready1 !== 1'b0 || rdata1 !== 128'h0) begin
         errors++;
         $display("FAIL reset_state: ready0=%b rdata0=%h ready1=%b rdata1=%h expected 0",
                  ready0, rdata0, ready1, rdata1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // First edge after release must accept.
      run_req("read_after_reset", 1'b0, 1'b0, 28'h0000005, '0, 4, 1'b1, 128'h0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      run_req("write_0x12", 1'b0, 1'b1, 28'h0000012, DataA, 4, 1'b0, '0);
      @(negedge clk);
      run_req("read_0x12", 1'b0, 1'b0, 28'h0000012, '0, 4, 1'b1, DataA);
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b0 || rdata0 !== DataA) begin
         errors++;
         $display("FAIL ready_pulse_hold: ready=%b rdata=%h expected 0 / %h",
                  ready0, rdata0, DataA);
      end
   endtask

   task automatic test_alias();
      @(negedge clk);
      run_req("write_0x112", 1'b0, 1'b1, 28'h0000112, DataB, 4, 1'b0, '0);
      @(negedge clk);
      run_req("read_alias_0x12", 1'b0, 1'b0, 28'h0000012, '0, 4, 1'b1, DataB);
      @(negedge clk);
      run_req("read_alias_high", 1'b0, 1'b0, 28'hABCDE12, '0, 4, 1'b1, DataB);
   endtask

   task automatic test_both_high();
      int stray = 0;
      @(negedge clk);
      read0 = 1'b1; write0 = 1'b1; addr0 = 28'h0000012; wdata0 = DataX;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ready0 !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL both_high_ready: got %0d ready cycles expected 0", stray);
      end
      // Still idle: a clean read must complete with full latency and untouched data.
      run_req("read_after_both", 1'b0, 1'b0, 28'h0000012, '0, 4, 1'b1, DataB);
   endtask

   task automatic test_hold_ignore();
      int  n = 1;
      bit  seen = 1'b0;
      @(negedge clk);
      write0 = 1'b1; addr0 = 28'h0000033; wdata0 = DataX;
      @(negedge clk);
      // In BUSY: drop request and scramble address/data.
      write0 = 1'b0; addr0 = 28'h0000034; wdata0 = DataY;
      for (int i = 2; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (ready0 === 1'b1) begin
            seen = 1'b1;
            n    = i;
         end
      end
      checks++;
      if (!seen || n != 4) begin
         errors++;
         $display("FAIL dropped_write_latency: got %0d (seen=%0d) expected 4", n, seen);
      end
      @(negedge clk);
      run_req("read_dropped_0x33", 1'b0, 1'b0, 28'h0000033, '0, 4, 1'b1, DataX);
      @(negedge clk);
      run_req("read_untouched_0x34", 1'b0, 1'b0, 28'h0000034, '0, 4, 1'b1, 128'h0);
      @(negedge clk);
      run_req("read_nonzero_0x33", 1'b0, 1'b0, 28'h0000033, '0, 4, 1'b1, DataX);
   endtask

   task automatic test_reset_mid();
      int stray = 0;
      @(negedge clk);
      write0 = 1'b1; addr0 = 28'h0000040; wdata0 = DataZ;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      write0 = 1'b0;
      #1;
      checks++;
      if (ready0 !== 1'b0 || rdata0 !== 128'h0) begin
         errors++;
         $display("FAIL async_reset: ready=%b rdata=%h expected 0 / 0", ready0, rdata0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ready0 !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL stray_ready_after_reset: got %0d ready cycles expected 0", stray);
      end
      run_req("read_dropped_write", 1'b0, 1'b0, 28'h0000040, '0, 4, 1'b1, 128'h0);
      @(negedge clk);
      run_req("read_cleared_0x12", 1'b0, 1'b0, 28'h0000012, '0, 4, 1'b1, 128'h0);
   endtask

   task automatic test_latency_one();
      @(negedge clk);
      run_req("lat1_read", 1'b1, 1'b0, 28'h0000007, '0, 1, 1'b1, 128'h0);
      @(negedge clk);
      run_req("lat1_write", 1'b1, 1'b1, 28'h0000007, DataW, 1, 1'b0, '0);
      @(negedge clk);
      run_req("lat1_readback", 1'b1, 1'b0, 28'h0000007, '0, 1, 1'b1, DataW);
      @(negedge clk);
      checks++;
      if (ready1 !== 1'b0 || rdata1 !== DataW) begin
         errors++;
         $display("FAIL lat1_pulse_hold: ready=%b rdata=%h expected 0 / %h",
                  ready1, rdata1, DataW);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_alias();
      test_both_high();
      test_hold_ignore();
      test_reset_mid();
      test_latency_one();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
